// File: rtl/syn_down_counter_pkg.sv
// rtl/syn_down_counter_pkg.sv - shared types and parameter defaults for syn_down_counter
package syn_down_counter_pkg;

    localparam int DEF_WIDTH    = 4;
    localparam int DEF_PRESCALE = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cnt_state_t;

endpackage

// File: rtl/syn_down_counter_if.sv
// rtl/syn_down_counter_if.sv - control/status bundle for syn_down_counter
// Ports: load, load_val, start, auto_reload (into the counter);
//        out, tc, busy (from the counter).
interface syn_down_counter_if #(
    parameter int WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             auto_reload;
    logic [WIDTH-1:0] out;
    logic             tc;
    logic             busy;

    modport master (
        output load, load_val, start, auto_reload,
        input  out, tc, busy
    );

    modport slave (
        input  load, load_val, start, auto_reload,
        output out, tc, busy
    );
endinterface

// File: rtl/syn_down_counter_tick_prescaler.sv
// rtl/syn_down_counter_tick_prescaler.sv - free-running clock-enable divider for syn_down_counter
// Ports: clk, rst (async active-low), clr (synchronous clear), en (count enable),
//        tick (high for one clk when the counter sits at 2^PRESCALE-1 while enabled).
module tick_prescaler #(
    parameter int PRESCALE = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);
    logic [PRESCALE-1:0] cnt_q;
    logic [PRESCALE-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + PRESCALE'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == '1);
endmodule

// File: rtl/syn_down_counter.sv
// rtl/syn_down_counter.sv - loadable down counter/timer with one-shot and auto-reload modes
// Ports: clk, rst (async active-low), bus (syn_down_counter_if.slave: load, load_val,
//        start, auto_reload in; out, tc, busy out).
// Macro DOWN_CNT_PRESCALE_EN: when defined, each decrement takes 2^PRESCALE clocks via
// tick_prescaler; when undefined, the count steps every clock in RUN.
module syn_down_counter
    import syn_down_counter_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic                clk,
    input  logic                rst,
    syn_down_counter_if.slave   bus
);
    cnt_state_t       state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;
    logic             busy_q, busy_d;
    logic             tick;

`ifdef DOWN_CNT_PRESCALE_EN
    // Restart the divider whenever RUN is entered so the first decrement
    // lands a full 2^PRESCALE clocks after start.
    logic pre_clr;
    assign pre_clr = bus.load || ((state_q != RUN) && (state_d == RUN));

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_tick_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (pre_clr),
        .en   (state_q == RUN),
        .tick (tick)
    );
`else
    logic unused_prescale;
    assign unused_prescale = ^PRESCALE;
    assign tick = (state_q == RUN);
`endif

    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        reload_d = reload_q;
        tc_d     = 1'b0;

        if (bus.load) begin
            // load overrides start and any tick on the same edge, and swallows tc
            out_d    = bus.load_val;
            reload_d = bus.load_val;
            state_d  = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (out_q != '0) begin
                            state_d = RUN;
                        end else begin
                            state_d = DONE;
                            tc_d    = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (tick) begin
                        // <= 1 rather than == 1 keeps the count from ever wrapping
                        if (out_q <= WIDTH'(1)) begin
                            tc_d = 1'b1;
                            if (bus.auto_reload) begin
                                out_d = reload_q;
                            end else begin
                                out_d   = '0;
                                state_d = DONE;
                            end
                        end else begin
                            out_d = out_q - WIDTH'(1);
                        end
                    end
                end
                DONE: begin
                    if (bus.start) begin
                        if (reload_q != '0) begin
                            out_d   = reload_q;
                            state_d = RUN;
                        end else begin
                            tc_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            out_q    <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.out  = out_q;
    assign bus.tc   = tc_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_syn_down_counter.sv
// tb/tb_syn_down_counter.sv - scoreboard bench for syn_down_counter
module tb_syn_down_counter;

    typedef struct packed {
        logic       load;
        logic [3:0] val;
        logic       start;
        logic       ar;
    } stim_t;

    typedef struct packed {
        logic [3:0] out;
        logic       tc;
        logic       busy;
    } exp_t;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    stim_t stim_q[$];
    exp_t  exp_q[$];

    syn_down_counter_if #(.WIDTH(4)) bus ();

    syn_down_counter #(
        .WIDTH    (4),
        .PRESCALE (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic ld, input logic [3:0] v, input logic st, input logic ar,
                       input logic [3:0] eo, input logic etc, input logic eb);
        stim_t s;
        exp_t  e;
        s = '{load: ld, val: v, start: st, ar: ar};
        e = '{out: eo, tc: etc, busy: eb};
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b0;
        bus.load = 1'b1; bus.load_val = 4'd9; bus.start = 1'b1; bus.auto_reload = 1'b0;
        for (int i = 0; i < 2; i++) exp_q.push_back('{out: 4'd0, tc: 1'b0, busy: 1'b0});
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_checks++;
            if ({bus.out, bus.tc, bus.busy} !== {e.out, e.tc, e.busy}) begin
                n_fail++;
                $display("FAIL reset_hold[%0d] out/tc/busy=%0d/%0b/%0b expected %0d/%0b/%0b",
                         i, bus.out, bus.tc, bus.busy, e.out, e.tc, e.busy);
            end
        end
        bus.load = 1'b0; bus.start = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back('{out: 4'd0, tc: 1'b0, busy: 1'b0});
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_checks++;
            if ({bus.out, bus.tc, bus.busy} !== {e.out, e.tc, e.busy}) begin
                n_fail++;
                $display("FAIL reset_release[%0d] out/tc/busy=%0d/%0b/%0b expected %0d/%0b/%0b",
                         i, bus.out, bus.tc, bus.busy, e.out, e.tc, e.busy);
            end
        end
    endtask

    task automatic test_one_shot();
        stim_t s;
        exp_t  e;
        add(1, 4'd5, 0, 0, 4'd5, 0, 0);
        add(0, 4'd0, 1, 0, 4'd5, 0, 1);
        add(0, 4'd0, 0, 0, 4'd4, 0, 1);
        add(0, 4'd0, 0, 0, 4'd3, 0, 1);
        add(0, 4'd0, 0, 0, 4'd2, 0, 1);
        add(0, 4'd0, 0, 0, 4'd1, 0, 1);
        add(0, 4'd0, 0, 0, 4'd0, 1, 0);
        add(0, 4'd0, 0, 0, 4'd0, 0, 0);
        add(0, 4'd0, 1, 0, 4'd5, 0, 1);
        add(0, 4'd0, 0, 0, 4'd4, 0, 1);
        add(0, 4'd0, 1, 0, 4'd3, 0, 1);
        for (int i = 0; stim_q.size() > 0; i++) begin
            s = stim_q.pop_front();
            bus.load = s.load; bus.load_val = s.val; bus.start = s.start; bus.auto_reload = s.ar;
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_checks++;
            if ({bus.out, bus.tc, bus.busy} !== {e.out, e.tc, e.busy}) begin
                n_fail++;
                $display("FAIL one_shot[%0d] out/tc/busy=%0d/%0b/%0b expected %0d/%0b/%0b",
                         i, bus.out, bus.tc, bus.busy, e.out, e.tc, e.busy);
            end
        end
    endtask

    task automatic test_auto_reload();
        stim_t s;
        exp_t  e;
        add(1, 4'd3, 0, 1, 4'd3, 0, 0);
        add(0, 4'd0, 1, 1, 4'd3, 0, 1);
        add(0, 4'd0, 0, 1, 4'd2, 0, 1);
        add(0, 4'd0, 0, 1, 4'd1, 0, 1);
        add(0, 4'd0, 0, 1, 4'd3, 1, 1);
        add(0, 4'd0, 0, 1, 4'd2, 0, 1);
        add(0, 4'd0, 0, 1, 4'd1, 0, 1);
        add(0, 4'd0, 0, 1, 4'd3, 1, 1);
        add(0, 4'd0, 0, 1, 4'd2, 0, 1);
        add(0, 4'd0, 0, 0, 4'd1, 0, 1);
        add(0, 4'd0, 0, 0, 4'd0, 1, 0);
        add(0, 4'd0, 0, 0, 4'd0, 0, 0);
        for (int i = 0; stim_q.size() > 0; i++) begin
            s = stim_q.pop_front();
            bus.load = s.load; bus.load_val = s.val; bus.start = s.start; bus.auto_reload = s.ar;
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_checks++;
            if ({bus.out, bus.tc, bus.busy} !== {e.out, e.tc, e.busy}) begin
                n_fail++;
                $display("FAIL auto_reload[%0d] out/tc/busy=%0d/%0b/%0b expected %0d/%0b/%0b",
                         i, bus.out, bus.tc, bus.busy, e.out, e.tc, e.busy);
            end
        end
    endtask

    task automatic test_load_start();
        stim_t s;
        exp_t  e;
        add(1, 4'd6, 0, 0, 4'd6, 0, 0);
        add(0, 4'd0, 1, 0, 4'd6, 0, 1);
        add(0, 4'd0, 0, 0, 4'd5, 0, 1);
        add(0, 4'd0, 0, 0, 4'd4, 0, 1);
        add(1, 4'd9, 0, 0, 4'd9, 0, 0);   // load mid-run
        add(0, 4'd0, 0, 0, 4'd9, 0, 0);
        add(1, 4'd3, 1, 0, 4'd3, 0, 0);   // load beats start
        add(0, 4'd0, 0, 0, 4'd3, 0, 0);
        add(1, 4'd0, 0, 0, 4'd0, 0, 0);
        add(0, 4'd0, 1, 0, 4'd0, 1, 0);   // start at zero -> DONE with tc
        add(0, 4'd0, 0, 0, 4'd0, 0, 0);
        add(0, 4'd0, 1, 0, 4'd0, 1, 0);   // start in DONE with empty reload
        add(1, 4'd1, 0, 0, 4'd1, 0, 0);
        add(0, 4'd0, 1, 0, 4'd1, 0, 1);
        add(1, 4'd7, 0, 0, 4'd7, 0, 0);   // load on terminal tick suppresses tc
        add(0, 4'd0, 0, 0, 4'd7, 0, 0);
        for (int i = 0; stim_q.size() > 0; i++) begin
            s = stim_q.pop_front();
            bus.load = s.load; bus.load_val = s.val; bus.start = s.start; bus.auto_reload = s.ar;
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_checks++;
            if ({bus.out, bus.tc, bus.busy} !== {e.out, e.tc, e.busy}) begin
                n_fail++;
                $display("FAIL load_start[%0d] out/tc/busy=%0d/%0b/%0b expected %0d/%0b/%0b",
                         i, bus.out, bus.tc, bus.busy, e.out, e.tc, e.busy);
            end
        end
    endtask

    task automatic test_prescale();
        stim_t s;
        exp_t  e;
        add(1, 4'd2, 0, 0, 4'd2, 0, 0);
        add(0, 4'd0, 1, 0, 4'd2, 0, 1);
        for (int i = 0; i < 3; i++) add(0, 4'd0, 0, 0, 4'd2, 0, 1);
        add(0, 4'd0, 0, 0, 4'd1, 0, 1);
        for (int i = 0; i < 3; i++) add(0, 4'd0, 0, 0, 4'd1, 0, 1);
        add(0, 4'd0, 0, 0, 4'd0, 1, 0);
        add(0, 4'd0, 0, 0, 4'd0, 0, 0);
        for (int i = 0; stim_q.size() > 0; i++) begin
            s = stim_q.pop_front();
            bus.load = s.load; bus.load_val = s.val; bus.start = s.start; bus.auto_reload = s.ar;
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_checks++;
            if ({bus.out, bus.tc, bus.busy} !== {e.out, e.tc, e.busy}) begin
                n_fail++;
                $display("FAIL prescale[%0d] out/tc/busy=%0d/%0b/%0b expected %0d/%0b/%0b",
                         i, bus.out, bus.tc, bus.busy, e.out, e.tc, e.busy);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        stim_t s;
        exp_t  e;
        add(1, 4'd5, 0, 0, 4'd5, 0, 0);
        add(0, 4'd0, 1, 0, 4'd5, 0, 1);
        add(0, 4'd0, 0, 0, 4'd4, 0, 1);
        add(0, 4'd0, 0, 0, 4'd3, 0, 1);
        for (int i = 0; stim_q.size() > 0; i++) begin
            s = stim_q.pop_front();
            bus.load = s.load; bus.load_val = s.val; bus.start = s.start; bus.auto_reload = s.ar;
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_checks++;
            if ({bus.out, bus.tc, bus.busy} !== {e.out, e.tc, e.busy}) begin
                n_fail++;
                $display("FAIL mid_run_pre[%0d] out/tc/busy=%0d/%0b/%0b expected %0d/%0b/%0b",
                         i, bus.out, bus.tc, bus.busy, e.out, e.tc, e.busy);
            end
        end
        // Assert reset between edges and look before the next edge arrives.
        #2 rst = 1'b0;
        exp_q.push_back('{out: 4'd0, tc: 1'b0, busy: 1'b0});
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if ({bus.out, bus.tc, bus.busy} !== {e.out, e.tc, e.busy}) begin
            n_fail++;
            $display("FAIL mid_run_async out/tc/busy=%0d/%0b/%0b expected %0d/%0b/%0b",
                     bus.out, bus.tc, bus.busy, e.out, e.tc, e.busy);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 6; i++) exp_q.push_back('{out: 4'd0, tc: 1'b0, busy: 1'b0});
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_checks++;
            if ({bus.out, bus.tc, bus.busy} !== {e.out, e.tc, e.busy}) begin
                n_fail++;
                $display("FAIL mid_run_after[%0d] out/tc/busy=%0d/%0b/%0b expected %0d/%0b/%0b",
                         i, bus.out, bus.tc, bus.busy, e.out, e.tc, e.busy);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        bus.load = 1'b0; bus.load_val = 4'd0; bus.start = 1'b0; bus.auto_reload = 1'b0;
        test_reset();
`ifdef DOWN_CNT_PRESCALE_EN
        test_prescale();
`else
        test_one_shot();
        test_auto_reload();
        test_load_start();
        test_reset_mid_run();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
